// File: rtl/verify_ram.sv
// verify_ram: read-back checker for a bank that was filled with a constant byte.
// It issues INCR read bursts over the AXI4 AR channel and compares every R beat
// against FILL_VALUE replicated across all byte lanes.
//
// Ports:
//   ram_clk, ram_reset       sole clock; synchronous active-high reset
//   start                    one-cycle pulse, honoured only while idle=1
//   idle                     high when no verify pass is in progress
//   mismatch_count           number of beats whose data differed (saturating)
//   first_bad_addr/_valid    byte address of the first mismatching beat
//   resp_err                 sticky: some beat returned RRESP != OKAY
//   last_err                 sticky: RLAST misplaced relative to the beat count
//   elapsed                  cycles from start until idle reasserts
//   M_AXI_AR* / M_AXI_R*     AXI4 read address and read data channels
//   ar_state, r_state        current state of the AR and R machines (debug)
//
// Handshake semantics: a transfer happens on a rising edge where VALID and
// READY are both high. Once ARVALID is raised it stays high, with ARADDR
// stable, until that transfer occurs. RREADY is high for the whole pass, so
// every RVALID beat is accepted on the cycle it is presented.
module verify_ram #(
  parameter int          DW               = 512,
  parameter logic [7:0]  FILL_VALUE       = 8'hFC,
  parameter logic [63:0] BASE_ADDR        = 64'h0,
  parameter int          BLOCK_SIZE       = 4096,
  parameter int          CYCLES_PER_BLOCK = 64,
  parameter int          BLOCKS           = 1024,
  parameter int          MAX_OUTSTANDING  = 8
) (
  input  logic          ram_clk,
  input  logic          ram_reset,
  input  logic          start,
  output logic          idle,
  output logic [31:0]   mismatch_count,
  output logic [63:0]   first_bad_addr,
  output logic          first_bad_valid,
  output logic          resp_err,
  output logic          last_err,
  output logic [63:0]   elapsed,
  output logic [63:0]   M_AXI_ARADDR,
  output logic [7:0]    M_AXI_ARLEN,
  output logic [2:0]    M_AXI_ARSIZE,
  output logic [1:0]    M_AXI_ARBURST,
  output logic [3:0]    M_AXI_ARID,
  output logic          M_AXI_ARLOCK,
  output logic [3:0]    M_AXI_ARCACHE,
  output logic [3:0]    M_AXI_ARQOS,
  output logic [2:0]    M_AXI_ARPROT,
  output logic          M_AXI_ARVALID,
  input  logic          M_AXI_ARREADY,
  input  logic [DW-1:0] M_AXI_RDATA,
  input  logic [1:0]    M_AXI_RRESP,
  input  logic          M_AXI_RLAST,
  input  logic          M_AXI_RVALID,
  output logic          M_AXI_RREADY,
  output logic [0:0]    ar_state,
  output logic [1:0]    r_state
);

  localparam logic [0:0] AR_IDLE  = 1'b0;
  localparam logic [0:0] AR_ISSUE = 1'b1;

  localparam logic [1:0] R_IDLE  = 2'd0;
  localparam logic [1:0] R_RUN   = 2'd1;  // addresses still being issued
  localparam logic [1:0] R_DRAIN = 2'd2;  // all addresses issued, data pending

  localparam logic [DW-1:0] PATTERN    = {(DW/8){FILL_VALUE}};
  localparam logic [63:0]   BLOCK_STEP = 64'(BLOCK_SIZE);
  localparam logic [63:0]   BEAT_STEP  = 64'(DW/8);
  localparam logic [8:0]    LAST_BEAT  = 9'(CYCLES_PER_BLOCK);
  localparam logic [31:0]   BLOCKS_W   = 32'(BLOCKS);
  localparam logic [31:0]   MAX_OUT_W  = 32'(MAX_OUTSTANDING);

  assign M_AXI_ARLEN   = 8'(CYCLES_PER_BLOCK - 1);
  assign M_AXI_ARSIZE  = 3'($clog2(DW/8));
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARID    = 4'd0;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'd0;
  assign M_AXI_ARQOS   = 4'd0;
  assign M_AXI_ARPROT  = 3'd0;

  logic [31:0] ar_issued;
  logic [31:0] r_done;
  logic [8:0]  beat;       // 1..CYCLES_PER_BLOCK, beat expected next
  logic [63:0] beat_addr;

  logic        ar_hs;
  logic        r_hs;
  logic        burst_end;
  logic [31:0] ar_issued_nxt;
  logic [31:0] r_done_nxt;
  logic        window_open;
  logic        beat_bad;
  logic        pass_done;

  always_comb begin
    ar_hs         = M_AXI_ARVALID & M_AXI_ARREADY;
    r_hs          = M_AXI_RVALID & M_AXI_RREADY;
    // A burst is counted complete by beat count alone; RLAST only feeds last_err.
    burst_end     = r_hs && (beat == LAST_BEAT);
    ar_issued_nxt = ar_issued + {31'b0, ar_hs};
    r_done_nxt    = r_done + {31'b0, burst_end};
    // Uses post-update counters so a handshake that fills the window drops
    // ARVALID on the next cycle, and a simultaneous completion reopens it.
    window_open   = (ar_issued_nxt - r_done_nxt) < MAX_OUT_W;
    beat_bad      = (M_AXI_RDATA != PATTERN);
    pass_done     = burst_end && (r_done_nxt == BLOCKS_W);
  end

  always_ff @(posedge ram_clk) begin
    if (ram_reset) begin
      idle            <= 1'b1;
      ar_state        <= AR_IDLE;
      r_state         <= R_IDLE;
      M_AXI_ARVALID   <= 1'b0;
      M_AXI_RREADY    <= 1'b0;
      M_AXI_ARADDR    <= BASE_ADDR;
      ar_issued       <= 32'd0;
      r_done          <= 32'd0;
      beat            <= 9'd1;
      beat_addr       <= BASE_ADDR;
      mismatch_count  <= 32'd0;
      first_bad_addr  <= 64'd0;
      first_bad_valid <= 1'b0;
      resp_err        <= 1'b0;
      last_err        <= 1'b0;
      elapsed         <= 64'd0;
    end else if (idle) begin
      if (start) begin
        idle            <= 1'b0;
        ar_state        <= AR_ISSUE;
        r_state         <= R_RUN;
        M_AXI_ARVALID   <= 1'b1;  // window is empty, always open here
        M_AXI_RREADY    <= 1'b1;
        M_AXI_ARADDR    <= BASE_ADDR;
        ar_issued       <= 32'd0;
        r_done          <= 32'd0;
        beat            <= 9'd1;
        beat_addr       <= BASE_ADDR;
        mismatch_count  <= 32'd0;
        first_bad_addr  <= 64'd0;
        first_bad_valid <= 1'b0;
        resp_err        <= 1'b0;
        last_err        <= 1'b0;
        elapsed         <= 64'd0;
      end
    end else begin
      elapsed   <= elapsed + 64'd1;
      ar_issued <= ar_issued_nxt;
      r_done    <= r_done_nxt;

      // Address issue: the window gate is only consulted while ARVALID is low
      // or is being consumed this cycle, so a pending request is never withdrawn.
      if (ar_state == AR_ISSUE) begin
        if (ar_hs) begin
          M_AXI_ARADDR <= M_AXI_ARADDR + BLOCK_STEP;
        end
        if (ar_issued_nxt == BLOCKS_W) begin
          ar_state      <= AR_IDLE;
          M_AXI_ARVALID <= 1'b0;
        end else if (!M_AXI_ARVALID || ar_hs) begin
          M_AXI_ARVALID <= window_open;
        end
      end

      if ((r_state == R_RUN) && (ar_issued_nxt == BLOCKS_W)) begin
        r_state <= R_DRAIN;
      end

      if (r_hs) begin
        if (beat_bad) begin
          if (mismatch_count != 32'hFFFF_FFFF) begin
            mismatch_count <= mismatch_count + 32'd1;
          end
          if (!first_bad_valid) begin
            first_bad_addr  <= beat_addr;
            first_bad_valid <= 1'b1;
          end
        end
        if (M_AXI_RRESP != 2'b00) begin
          resp_err <= 1'b1;
        end
        if (M_AXI_RLAST != (beat == LAST_BEAT)) begin
          last_err <= 1'b1;
        end
        beat_addr <= beat_addr + BEAT_STEP;
        beat      <= burst_end ? 9'd1 : beat + 9'd1;
      end

      if (pass_done) begin
        idle          <= 1'b1;
        M_AXI_RREADY  <= 1'b0;
        M_AXI_ARVALID <= 1'b0;
        ar_state      <= AR_IDLE;
        r_state       <= R_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_verify_ram.sv
// Directed bench for verify_ram: small bank (4 bursts of 4 beats, 64-byte beats)
// at 0x1000, window of 2 outstanding bursts, behavioural AXI read slave.
module tb_verify_ram;

  localparam int          DW      = 512;
  localparam logic [63:0] BASE    = 64'h1000;
  localparam int          BLKS    = 4;
  localparam int          CPB     = 4;
  localparam int          MAX_OUT = 2;

  // ---------------- clock / reset ----------------
  logic ram_clk = 1'b0;
  logic ram_reset;
  logic start;
  always #5 ram_clk = ~ram_clk;

  int cyc = 0;
  always @(posedge ram_clk) cyc <= cyc + 1;

  logic          idle;
  logic [31:0]   mismatch_count;
  logic [63:0]   first_bad_addr;
  logic          first_bad_valid;
  logic          resp_err;
  logic          last_err;
  logic [63:0]   elapsed;
  logic [63:0]   M_AXI_ARADDR;
  logic [7:0]    M_AXI_ARLEN;
  logic [2:0]    M_AXI_ARSIZE;
  logic [1:0]    M_AXI_ARBURST;
  logic [3:0]    M_AXI_ARID;
  logic          M_AXI_ARLOCK;
  logic [3:0]    M_AXI_ARCACHE;
  logic [3:0]    M_AXI_ARQOS;
  logic [2:0]    M_AXI_ARPROT;
  logic          M_AXI_ARVALID;
  logic          M_AXI_ARREADY;
  logic [DW-1:0] M_AXI_RDATA;
  logic [1:0]    M_AXI_RRESP;
  logic          M_AXI_RLAST;
  logic          M_AXI_RVALID;
  logic          M_AXI_RREADY;
  logic [0:0]    ar_state;
  logic [1:0]    r_state;

  verify_ram #(
    .DW(DW), .FILL_VALUE(8'hFC), .BASE_ADDR(BASE), .BLOCK_SIZE(256),
    .CYCLES_PER_BLOCK(CPB), .BLOCKS(BLKS), .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .ram_clk(ram_clk), .ram_reset(ram_reset), .start(start), .idle(idle),
    .mismatch_count(mismatch_count), .first_bad_addr(first_bad_addr),
    .first_bad_valid(first_bad_valid), .resp_err(resp_err), .last_err(last_err),
    .elapsed(elapsed), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_ARSIZE(M_AXI_ARSIZE), .M_AXI_ARBURST(M_AXI_ARBURST), .M_AXI_ARID(M_AXI_ARID),
    .M_AXI_ARLOCK(M_AXI_ARLOCK), .M_AXI_ARCACHE(M_AXI_ARCACHE), .M_AXI_ARQOS(M_AXI_ARQOS),
    .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RLAST(M_AXI_RLAST),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .ar_state(ar_state), .r_state(r_state)
  );

  // ---------------- checking ----------------
  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model / scoreboard ----------------
  logic [63:0] exp_q[$];      // expected AR addresses, in order
  int          ar_time_q[$];  // cycle each accepted burst became available
  int          sbeat, gbeat, outstanding, max_out, last_beat_cyc;
  bit          ar_rand, r_rand;
  int          r_delay, early_burst, resp_burst;
  logic [16:0] bad_beat;      // indexed by 1-based beat number within the pass
  logic        prev_stall;
  logic [63:0] prev_addr;
  logic [DW-1:0] pat;

  initial begin
    int nb, bi;
    pat = {64{8'hFC}};
    M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RDATA = '0;
    M_AXI_RRESP = 2'b00; M_AXI_RLAST = 1'b0;
    prev_stall = 1'b0; prev_addr = '0;
    sbeat = 0; gbeat = 0; outstanding = 0; max_out = 0; last_beat_cyc = 0;
    forever begin
      @(negedge ram_clk);
      if (ram_reset) begin
        M_AXI_ARREADY = 1'b0; M_AXI_RVALID = 1'b0; M_AXI_RLAST = 1'b0;
        ar_time_q.delete(); sbeat = 0; outstanding = 0; prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("arvalid_hold", 64'(M_AXI_ARVALID), 64'd1);
          check("araddr_hold", M_AXI_ARADDR, prev_addr);
        end
        M_AXI_ARREADY = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (ar_time_q.size() > 0 && cyc >= ar_time_q[0] + r_delay)
          M_AXI_RVALID = r_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        else
          M_AXI_RVALID = 1'b0;
        nb = sbeat + 1;
        bi = gbeat / CPB;
        M_AXI_RDATA = pat;
        if (gbeat + 1 <= 16 && bad_beat[gbeat + 1]) M_AXI_RDATA[7:0] = 8'h00;
        M_AXI_RLAST = (bi == early_burst) ? (nb == 3) : (nb == CPB);
        M_AXI_RRESP = (bi == resp_burst && nb == 2) ? 2'b10 : 2'b00;

        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          if (exp_q.size() > 0) check("araddr", M_AXI_ARADDR, exp_q.pop_front());
          else check("ar_unexpected", 64'(exp_q.size()), 64'd1);
          ar_time_q.push_back(cyc);
          outstanding++;
          if (outstanding > max_out) max_out = outstanding;
        end
        prev_stall = M_AXI_ARVALID && !M_AXI_ARREADY;
        prev_addr  = M_AXI_ARADDR;
        if (M_AXI_RVALID && M_AXI_RREADY) begin
          gbeat++;
          sbeat++;
          if (gbeat == BLKS * CPB) last_beat_cyc = cyc;
          if (sbeat == CPB) begin
            sbeat = 0;
            if (ar_time_q.size() > 0) void'(ar_time_q.pop_front());
            outstanding--;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge ram_clk);
    #1;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_idle"}, 64'(idle), 64'd1);
    check({pfx, "_arvalid"}, 64'(M_AXI_ARVALID), 64'd0);
    check({pfx, "_rready"}, 64'(M_AXI_RREADY), 64'd0);
    check({pfx, "_mismatch"}, 64'(mismatch_count), 64'd0);
    check({pfx, "_fbv"}, 64'(first_bad_valid), 64'd0);
    check({pfx, "_fba"}, first_bad_addr, 64'd0);
    check({pfx, "_resp_err"}, 64'(resp_err), 64'd0);
    check({pfx, "_last_err"}, 64'(last_err), 64'd0);
    check({pfx, "_elapsed"}, elapsed, 64'd0);
    check({pfx, "_ar_state"}, 64'(ar_state), 64'd0);
    check({pfx, "_r_state"}, 64'(r_state), 64'd0);
  endtask

  task automatic begin_pass();
    gbeat = 0; max_out = 0;
    for (int i = 0; i < BLKS; i++) exp_q.push_back(BASE + 64'(i * 256));
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Counts cycles with idle low after start was sampled; noisy pulses start mid-pass.
  task automatic wait_idle(input bit noisy, output int cycles);
    int n = 0;
    while (!idle && n < 2000) begin
      n++;
      start = noisy && (n % 7 == 3);
      tick();
    end
    start = 1'b0;
    if (n >= 2000) check("timeout_idle", 64'(idle), 64'd1);
    cycles = n;
  endtask

  task automatic run_pass(input bit noisy, output int cycles);
    begin_pass();
    wait_idle(noisy, cycles);
  endtask

  task automatic check_done(input string pfx, input int cycles, input logic [31:0] mm,
                            input logic fbv, input logic [63:0] fba,
                            input logic re, input logic le);
    check({pfx, "_idle"}, 64'(idle), 64'd1);
    check({pfx, "_rready"}, 64'(M_AXI_RREADY), 64'd0);
    check({pfx, "_beats"}, 64'(gbeat), 64'd16);
    check({pfx, "_ars_left"}, 64'(exp_q.size()), 64'd0);
    check({pfx, "_elapsed"}, elapsed, 64'(cycles));
    check({pfx, "_mismatch"}, 64'(mismatch_count), 64'(mm));
    check({pfx, "_fbv"}, 64'(first_bad_valid), 64'(fbv));
    if (fbv) check({pfx, "_fba"}, first_bad_addr, fba);
    check({pfx, "_resp_err"}, 64'(resp_err), 64'(re));
    check({pfx, "_last_err"}, 64'(last_err), 64'(le));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int cycles;
    int n;
    ram_reset = 1'b1; start = 1'b0;
    ar_rand = 0; r_rand = 0; r_delay = 0; early_burst = -1; resp_burst = -1;
    bad_beat = '0;
    repeat (3) tick();
    check_reset_values("rst");
    ram_reset = 1'b0;
    tick();

    // 1: clean pass, always-ready slave
    run_pass(1'b0, cycles);
    check_done("clean", cycles, 32'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    check("clean_elapsed_abs", elapsed, 64'd17);
    check("clean_idle_after_last", 64'(cyc - last_beat_cyc), 64'd1);
    check("clean_max_out", 64'(max_out), 64'd2);
    check("arlen", 64'(M_AXI_ARLEN), 64'd3);
    check("arsize", 64'(M_AXI_ARSIZE), 64'd6);
    check("arburst", 64'(M_AXI_ARBURST), 64'd1);
    check("arid", 64'(M_AXI_ARID), 64'd0);
    tick();

    // 2: beats 6 and 9 corrupted in byte 0
    bad_beat[6] = 1'b1; bad_beat[9] = 1'b1;
    run_pass(1'b0, cycles);
    check_done("bad", cycles, 32'd2, 1'b1, 64'h1140, 1'b0, 1'b0);
    bad_beat = '0;
    tick();

    // 3: slow data, random ARREADY; window must cap at 2
    r_delay = 20; ar_rand = 1;
    run_pass(1'b0, cycles);
    check_done("slow", cycles, 32'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    check("slow_max_out", 64'(max_out), 64'd2);
    r_delay = 0; ar_rand = 0;
    tick();

    // 4: early RLAST in burst index 1, SLVERR on a beat of burst index 2
    early_burst = 1; resp_burst = 2;
    run_pass(1'b0, cycles);
    check_done("proto", cycles, 32'd0, 1'b0, 64'd0, 1'b1, 1'b1);
    early_burst = -1; resp_burst = -1;
    tick();

    // 5: reset after 2 beats (first beat bad), then a pass with stray starts
    bad_beat[1] = 1'b1;
    begin_pass();
    n = 0;
    while (gbeat < 2 && n < 200) begin
      n++;
      tick();
    end
    check("pre_reset_beats", 64'(gbeat), 64'd2);
    check("pre_reset_mismatch", 64'(mismatch_count), 64'd1);
    ram_reset = 1'b1;
    tick();
    check_reset_values("midrst");
    exp_q.delete();
    bad_beat = '0;
    ram_reset = 1'b0;
    tick();
    run_pass(1'b1, cycles);
    check_done("rerun", cycles, 32'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    check("rerun_elapsed_abs", elapsed, 64'd17);
    tick();

    // 6: 50% backpressure on both channels
    ar_rand = 1; r_rand = 1;
    run_pass(1'b0, cycles);
    check_done("bp", cycles, 32'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    ar_rand = 0; r_rand = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/verify_ram.md
Name: verify_ram

Overview:
- Read-back checker that sits directly downstream of the RAM fill stage.
- After a bank has been filled with a constant byte, it reads the whole bank over the AXI4 read channel and compares every beat against the expected pattern.
- Reports mismatch count, first bad address, response errors and elapsed cycles.
- Sits on the same AXI4 master port and clock domain as the fill stage; the read channel is otherwise unused by that stage.

Parameters:
- DW, 512, AXI data width in bits (multiple of 8).
- FILL_VALUE, 8'hFC, expected byte value in every byte lane.
- BASE_ADDR, 64'h0, byte address of the first block of the bank.
- BLOCK_SIZE, 4096, bytes per burst; must equal CYCLES_PER_BLOCK*DW/8.
- CYCLES_PER_BLOCK, 64, beats per burst, 1..256.
- BLOCKS, 1024, bursts per bank, >=1.
- MAX_OUTSTANDING, 8, maximum AR bursts issued but not completed, 1..255.

Ports:
- ram_clk  in  1  sole clock; all logic on its rising edge.
- ram_reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse, synchronous to ram_clk; begins a verify pass.
- idle  out  1  high when no pass is in progress.
- mismatch_count  out  32  beats whose RDATA differed from the pattern (saturates at 2^32-1).
- first_bad_addr  out  64  byte address of the first mismatching beat.
- first_bad_valid  out  1  first_bad_addr is meaningful.
- resp_err  out  1  sticky: any beat returned RRESP!=0.
- last_err  out  1  sticky: RLAST absent on the final beat or present early.
- elapsed  out  64  ram_clk cycles from start until idle reasserts.
- M_AXI_ARADDR  out  64  burst address.
- M_AXI_ARLEN  out  8  constant CYCLES_PER_BLOCK-1.
- M_AXI_ARSIZE  out  3  constant $clog2(DW/8).
- M_AXI_ARBURST  out  2  constant 1 (INCR).
- M_AXI_ARID  out  4  constant 0.
- M_AXI_ARLOCK/ARCACHE/ARQOS/ARPROT  out  1/4/4/3  constant 0.
- M_AXI_ARVALID  out  1  address valid.
- M_AXI_ARREADY  in  1  slave ready.
- M_AXI_RDATA  in  DW  read data.
- M_AXI_RRESP  in  2  read response.
- M_AXI_RLAST  in  1  last beat of burst.
- M_AXI_RVALID  in  1  data valid.
- M_AXI_RREADY  out  1  master ready.

Behaviour:
- Reset values:
  - idle=1, ARVALID=0, RREADY=0.
  - mismatch_count=0, first_bad_valid=0, first_bad_addr=0.
  - resp_err=0, last_err=0, elapsed=0.
  - Reset mid-pass aborts immediately with these same values; the surrounding system is responsible for resetting the interconnect.
- start while idle=0 is ignored.
- start while idle=1, on the next cycle:
  - idle=0, ARADDR=BASE_ADDR, ARVALID=1, RREADY=1.
  - All counters and flags clear; elapsed=0.
- elapsed increments every cycle while idle=0.
- AR state machine (states IDLE, ISSUE):
  - An address handshake is ARVALID&ARREADY.
  - Track ar_issued, 32-bit.
  - On each handshake: ar_issued+1 and ARADDR+=BLOCK_SIZE.
  - ARVALID deasserts after the handshake that makes ar_issued==BLOCKS.
  - ARVALID is driven only when (ar_issued - r_done) < MAX_OUTSTANDING. Compute this registered: a handshake that fills the window drops ARVALID the next cycle.
  - ARVALID never drops without a handshake once asserted. The gate is evaluated only before raising ARVALID.
- R path (states IDLE, RUN, DRAIN):
  - A data handshake is RVALID&RREADY.
  - beat counter, 1..CYCLES_PER_BLOCK; beat_addr starts at BASE_ADDR and advances DW/8 per beat.
  - Mismatch: RDATA != {DW/8{FILL_VALUE}}.
    - mismatch_count+1, saturating.
    - On the first mismatch only: first_bad_addr=beat_addr, first_bad_valid=1.
  - RRESP!=0 sets resp_err. The data compare still runs on that beat.
  - RLAST must be high exactly when beat==CYCLES_PER_BLOCK; any disagreement sets last_err.
  - Burst completion is counted on beat==CYCLES_PER_BLOCK regardless of RLAST: r_done+1 and beat resets to 1.
- Completion:
  - When r_done reaches BLOCKS: RREADY=0 and idle=1 on the following cycle.
  - elapsed freezes; result outputs hold until the next start.
- Simultaneous AR handshake and burst completion in one cycle: both counters update and the outstanding difference stays consistent.
- Arithmetic:
  - ARADDR and beat_addr are 64-bit and wrap mod 2^64 without a flag.
  - Counters are 32-bit; BLOCKS must fit in 32 bits.

Test Plan:
- DW=512, BLOCKS=4, CYCLES_PER_BLOCK=4, BLOCK_SIZE=256, BASE_ADDR=0x1000; slave returns all 0xFC with ARREADY/RVALID always high -> 4 ARs at 0x1000/0x1100/0x1200/0x1300, 16 beats, mismatch_count=0, first_bad_valid=0, idle rises one cycle after the 16th beat.
- Same setup, beats 6 and 9 carry byte 0 = 0x00 -> mismatch_count=2, first_bad_addr=0x1140, first_bad_valid=1.
- MAX_OUTSTANDING=2, slave delays R data 20 cycles -> never more than 2 bursts outstanding; ARVALID held with ARADDR stable until ARREADY.
- Burst 2 returns RLAST on beat 3, and burst 3 has RRESP=2 on one beat -> last_err=1, resp_err=1, pass still completes after 16 beats.
- Reset asserted after 2 beats, then start again -> all outputs return to reset values, the second pass completes normally, mismatch_count=0; start pulses during the pass are ignored.
- Random ARREADY/RVALID backpressure (50%) -> elapsed equals the measured number of cycles from start to idle.
